// File: rtl/ram_burst_reader_pkg.sv
// Shared types and sizing for the RAM burst reader.
package ram_burst_reader_pkg;

    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned FIFO_IDX_WIDTH = $clog2(FIFO_DEPTH);
    // Credits and FIFO occupancy both span 0..FIFO_DEPTH inclusive.
    localparam int unsigned CREDIT_WIDTH   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Command, RAM read port and output stream of the burst reader.
interface ram_burst_reader_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 4
);

    logic                  start_valid;
    logic                  start_ready;
    logic [ADDR_WIDTH:0]   start_addr;
    logic [ADDR_WIDTH:0]   start_len;
    logic [ADDR_WIDTH:0]   raddr_0;
    logic [WIDTH-1:0]      rdata_0;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    // Environment side: issues commands, models the RAM, consumes beats.
    modport master (
        output start_valid, start_addr, start_len, rdata_0, out_ready,
        input  start_ready, raddr_0, out_valid, out_data, out_last, busy, done
    );

    // Reader side.
    modport slave (
        input  start_valid, start_addr, start_len, rdata_0, out_ready,
        output start_ready, raddr_0, out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/ram_burst_reader_beat_fifo.sv
// Four-entry shift FIFO of {last, data}; the head slot is a flop that drives the output stream.
module ram_burst_reader_beat_fifo
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_last,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic             last,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH:0]          slots   [FIFO_DEPTH];
    logic [WIDTH:0]          slots_n [FIFO_DEPTH];
    logic [CREDIT_WIDTH-1:0] count;
    logic [CREDIT_WIDTH-1:0] count_n;
    logic                    pop_c;

    assign pop_c = pop && valid;

    // Next contents: pop shifts toward the head, push lands behind the last live entry.
    always_comb begin
        slots_n = slots;
        count_n = count;
        if (pop_c) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                slots_n[i] = slots[i + 1];
            end
            count_n = count - CREDIT_WIDTH'(1);
        end
        if (push) begin
            slots_n[count_n[FIFO_IDX_WIDTH-1:0]] = {push_last, push_data};
            count_n = count_n + CREDIT_WIDTH'(1);
        end
    end

    // Storage, occupancy and registered valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slots[i] <= '0;
            end
            count <= '0;
            valid <= 1'b0;
        end else begin
            slots <= slots_n;
            count <= count_n;
            valid <= (count_n != '0);
        end
    end

    assign data = slots[0][WIDTH-1:0];
    assign last = slots[0][WIDTH];

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read engine: walks a RAM range one read per cycle and streams the words out,
// with credits bounding reads in flight plus buffered beats to the FIFO depth.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    ram_burst_reader_if.slave  bus
);

    localparam int unsigned     AW        = ADDR_WIDTH + 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    state_t                  state;
    logic [AW-1:0]           addr;
    logic [AW-1:0]           remaining;
    logic [CREDIT_WIDTH-1:0] credits;
    logic                    inflight;
    logic                    inflight_last;
    logic                    start_ready;
    logic                    busy;
    logic                    done;
    logic                    fifo_valid;
    logic                    issue_c;
    logic                    pop_c;
    logic                    drain_done_c;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    // Issue depends only on registered state, never on out_ready.
    assign issue_c = (state == ISSUE) && (credits != '0);
    assign pop_c   = fifo_valid && bus.out_ready;

    // All credits home (or the final one returning this cycle) means nothing in flight or buffered.
    assign drain_done_c = (credits == CREDIT_WIDTH'(FIFO_DEPTH)) ||
                          (pop_c && (credits == CREDIT_WIDTH'(FIFO_DEPTH - 1)));

    // Control FSM, credit counter and in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            credits       <= CREDIT_WIDTH'(FIFO_DEPTH);
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            start_ready   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            credits       <= credits - CREDIT_WIDTH'(issue_c) + CREDIT_WIDTH'(pop_c);
            inflight      <= issue_c;
            inflight_last <= issue_c && (remaining == AW'(1));
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    start_ready <= 1'b1;
                    if (bus.start_valid && start_ready) begin
                        addr        <= bus.start_addr;
                        remaining   <= bus.start_len;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        // Zero-length commands hop through DRAIN so done keeps a two-cycle latency.
                        state       <= (bus.start_len == '0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_c) begin
                        remaining <= remaining - AW'(1);
                        // Keep the final address on raddr_0 once the burst is fully issued.
                        if (remaining == AW'(1)) begin
                            state <= DRAIN;
                        end else begin
                            addr <= next_addr(addr);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done_c) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_burst_reader_beat_fifo #(
        .WIDTH (WIDTH)
    ) beat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_last (inflight_last),
        .push_data (bus.rdata_0),
        .pop       (bus.out_ready),
        .valid     (fifo_valid),
        .last      (bus.out_last),
        .data      (bus.out_data)
    );

    assign bus.start_ready = start_ready;
    assign bus.raddr_0     = addr;
    assign bus.out_valid   = fifo_valid;
    assign bus.busy        = busy;
    assign bus.done        = done;

endmodule
